// File: rtl/wb_reg_spi_sequencer.sv
// Wishbone-driven serialiser for the raybox register SPI port, arbitrated against the LA bit-bang path.
// Optional IRQ output is enabled by defining WB_REG_SPI_IRQ_EN.
module wb_reg_spi_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        i_la_own,
  input  logic        i_la_csb,
  input  logic        i_la_sclk,
  input  logic        i_la_mosi,
  output logic        o_reg_csb,
  output logic        o_reg_sclk,
  output logic        o_reg_mosi
`ifdef WB_REG_SPI_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [5:0]  idx, idx_n;
  logic        csb_q, sclk_q, mosi_q, csb_n, sclk_n, mosi_n, done;
  logic [31:0] data0, data1, rdata, dat_q;
  logic [63:0] frame;
  logic [6:0]  len, len_w, len_src, len_eff;
  logic [7:0]  frame_cnt;
  logic [1:0]  reg_sel;
  logic        overrun, lenerr, pending, owner_la, ack;
  logic        decode, accept, wr, rd, busy, start_ok, launch;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];
  // DATA registers cannot change while BUSY, so the frame is shifted straight out of them.
  assign frame = {data1, data0};

  always_comb begin
    decode   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    accept   = wbs_stb_i & wbs_cyc_i & decode & ~ack;
    wr       = accept & wbs_we_i;
    rd       = accept & ~wbs_we_i;
    reg_sel  = wbs_adr_i[3:2];
    busy     = (state != S_IDLE) | pending;
    len_w    = wbs_sel_i[0] ? wbs_dat_i[6:0] : len;
    start_ok = wr & (reg_sel == 2'd2) & wbs_sel_i[1] & wbs_dat_i[8] & ~busy & (len_w != 7'd0);
    len_src  = start_ok ? len_w : len;
    len_eff  = (len_src > 7'd64) ? 7'd64 : len_src;
    launch   = (state == S_IDLE) & ~owner_la & (pending | start_ok);
    case (reg_sel)
      2'd0:    rdata = data0;
      2'd1:    rdata = data1;
      2'd2:    rdata = {25'd0, len};
      default: rdata = {16'd0, frame_cnt, 4'd0, lenerr, overrun, owner_la, busy};
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    idx_n   = idx;
    csb_n   = csb_q;
    sclk_n  = sclk_q;
    mosi_n  = mosi_q;
    done    = 1'b0;
    case (state)
      S_IDLE: if (launch) begin
        state_n = S_SETUP;
        cnt_n   = DIV_M1;
        idx_n   = 6'(len_eff - 7'd1);
        csb_n   = 1'b0;
        sclk_n  = 1'b0;
        mosi_n  = frame[6'(len_eff - 7'd1)];
      end
      S_SETUP: if (cnt == 8'd0) begin
        state_n = S_HIGH;
        cnt_n   = DIV_M1;
        sclk_n  = 1'b1;
      end
      S_HIGH: if (cnt == 8'd0) begin
        cnt_n  = DIV_M1;
        sclk_n = 1'b0;
        if (idx == 6'd0) begin
          state_n = S_HOLD;
        end else begin
          state_n = S_LOW;
          idx_n   = idx - 6'd1;
          mosi_n  = frame[idx - 6'd1];
        end
      end
      S_LOW: if (cnt == 8'd0) begin
        state_n = S_HIGH;
        cnt_n   = DIV_M1;
        sclk_n  = 1'b1;
      end
      S_HOLD: if (cnt == 8'd0) begin
        state_n = S_GAP;
        cnt_n   = DIV_M1;
        csb_n   = 1'b1;
        mosi_n  = 1'b0;
      end
      S_GAP: if (cnt == 8'd0) begin
        state_n = S_IDLE;
        done    = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      idx    <= 6'd0;
      csb_q  <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      csb_q  <= csb_n;
      sclk_q <= sclk_n;
      mosi_q <= mosi_n;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack       <= 1'b0;
      dat_q     <= 32'd0;
      data0     <= 32'd0;
      data1     <= 32'd0;
      len       <= 7'd0;
      overrun   <= 1'b0;
      lenerr    <= 1'b0;
      pending   <= 1'b0;
      owner_la  <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      ack   <= accept;
      dat_q <= rd ? rdata : 32'd0;
      if (wr) begin
        case (reg_sel)
          2'd0, 2'd1: begin
            if (busy) overrun <= 1'b1;
            else for (int b = 0; b < 4; b++)
              if (wbs_sel_i[b]) begin
                if (reg_sel == 2'd0) data0[8*b +: 8] <= wbs_dat_i[8*b +: 8];
                else                 data1[8*b +: 8] <= wbs_dat_i[8*b +: 8];
              end
          end
          2'd2: begin
            if (busy) overrun <= 1'b1;
            else begin
              if (wbs_sel_i[0]) len <= wbs_dat_i[6:0];
              if (wbs_sel_i[1] && wbs_dat_i[8] && len_w == 7'd0) lenerr <= 1'b1;
            end
          end
          default: if (wbs_sel_i[0]) begin
            if (wbs_dat_i[2]) overrun <= 1'b0;
            if (wbs_dat_i[3]) lenerr  <= 1'b0;
          end
        endcase
      end
      if (launch)                  pending <= 1'b0;
      else if (start_ok && owner_la) pending <= 1'b1;
      // A START accepted in the same cycle as an LA request keeps the port for the frame.
      if (owner_la) begin
        if (!i_la_own) owner_la <= 1'b0;
      end else if (i_la_own && state == S_IDLE && !pending && !start_ok) begin
        owner_la <= 1'b1;
      end
      if (done) frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef WB_REG_SPI_IRQ_EN
  logic irq;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                        irq <= 1'b0;
    else if (done)                       irq <= 1'b1;
    else if (rd && reg_sel == 2'd3)      irq <= 1'b0;
  end
  assign o_irq = irq;
`endif

  assign wbs_ack_o  = ack;
  assign wbs_dat_o  = dat_q;
  assign o_reg_csb  = owner_la ? i_la_csb  : csb_q;
  assign o_reg_sclk = owner_la ? i_la_sclk : sclk_q;
  assign o_reg_mosi = owner_la ? i_la_mosi : mosi_q;

endmodule

// File: tb/tb_wb_reg_spi_sequencer.sv
// Directed bench for wb_reg_spi_sequencer with a cycle-indexed behavioural model of frames and ownership.
module tb_wb_reg_spi_sequencer;
  localparam int          CLK_DIV = 2;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int          INF     = 1_000_000_000;

  logic clk = 1'b0, rst = 1'b1;
  logic wbs_stb = 0, wbs_cyc = 0, wbs_we = 0;
  logic [3:0] wbs_sel = 0;
  logic [31:0] wbs_adr = 0, wbs_dat = 0, wbs_dat_o;
  logic wbs_ack;
  logic la_own = 0, la_csb = 1, la_sclk = 0, la_mosi = 0;
  logic csb, sclk, mosi;
`ifdef WB_REG_SPI_IRQ_EN
  logic irq;
`endif

  wb_reg_spi_sequencer #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb), .wbs_cyc_i(wbs_cyc), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_o),
    .i_la_own(la_own), .i_la_csb(la_csb), .i_la_sclk(la_sclk), .i_la_mosi(la_mosi),
    .o_reg_csb(csb), .o_reg_sclk(sclk), .o_reg_mosi(mosi)
`ifdef WB_REG_SPI_IRQ_EN
    , .o_irq(irq)
`endif
  );

  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int n_checks = 0, n_errors = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model state: registers, one scheduled frame (by cycle), LA ownership window.
  logic [31:0] m_d0 = 0, m_d1 = 0;
  logic [6:0]  m_len_reg = 0;
  logic [63:0] m_frame = 0;
  bit m_ovr = 0, m_lerr = 0, m_active = 0, m_pend = 0;
  int m_busy_from = 0, m_start = 0, m_total = 0, m_len = 0, m_done = 0;
  int m_la_on = INF, m_la_off = INF;

  function automatic bit f_la(int c);
    return c >= m_la_on && c < m_la_off;
  endfunction
  function automatic bit f_busy(int c);
    return m_active && c >= m_busy_from && (m_pend || c < m_start + m_total);
  endfunction
  function automatic bit f_fin(int c);
    return m_active && !m_pend && c >= m_start + m_total;
  endfunction
  function automatic logic [31:0] f_reg(logic [1:0] r, int c);
    int n;
    n = (m_done + int'(f_fin(c))) % 256;
    case (r)
      2'd0:    return m_d0;
      2'd1:    return m_d1;
      2'd2:    return {25'd0, m_len_reg};
      default: return {16'd0, 8'(n), 4'd0, m_lerr, m_ovr, f_la(c), f_busy(c)};
    endcase
  endfunction
  function automatic logic [2:0] f_out(int c);
    int k, l;
    if (f_la(c)) return {la_csb, la_sclk, la_mosi};
    if (m_active && !m_pend && c >= m_start && c < m_start + m_total) begin
      l = m_len;
      k = (c - m_start) / CLK_DIV;
      if (k == 0)     return {2'b00, m_frame[l-1]};
      if (k < 2 * l)  return {1'b0, k[0], m_frame[l-1-k/2]};
      if (k == 2 * l) return {2'b00, m_frame[0]};
    end
    return 3'b100;
  endfunction

  task automatic model_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s, input int c);
    bit b;
    b = f_busy(c);
    if (r == 2'd3) begin
      if (s[0] && d[2]) m_ovr = 0;
      if (s[0] && d[3]) m_lerr = 0;
    end else if (b) begin
      m_ovr = 1;
    end else if (r == 2'd2) begin
      if (s[0]) m_len_reg = d[6:0];
      if (s[1] && d[8]) begin
        if (m_len_reg == 0) m_lerr = 1;
        else begin
          if (f_fin(c)) m_done++;
          m_active = 1;
          m_len = (m_len_reg > 64) ? 64 : int'(m_len_reg);
          m_total = CLK_DIV * (2 * m_len + 2);
          m_frame = {m_d1, m_d0};
          m_busy_from = c + 1;
          m_pend = f_la(c);
          m_start = m_pend ? INF : c + 1;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if (s[i]) begin
          if (r == 2'd0) m_d0[8*i +: 8] = d[8*i +: 8];
          else           m_d1[8*i +: 8] = d[8*i +: 8];
        end
    end
  endtask

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) check("spi_pins", {csb, sclk, mosi}, f_out(cyc_n));

  int rises = 0;
  logic [63:0] bits = 0;
  logic prev_sclk = 0;
  always @(negedge clk) begin
    if (!prev_sclk && sclk && !csb) begin
      rises++;
      bits = {bits[62:0], mosi};
    end
    prev_sclk = sclk;
  end

  task automatic goto(input int n);
    while (cyc_n < n) begin @(posedge clk); #1; end
  endtask

  task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rd);
    int c; bit dec; logic [31:0] exp;
    c = cyc_n;
    dec = (a[31:4] == BASE[31:4]);
    exp = f_reg(a[3:2], c);
    wbs_stb = 1; wbs_cyc = 1; wbs_we = w; wbs_adr = a; wbs_dat = d; wbs_sel = s;
    if (dec && w) model_write(a[3:2], d, s, c);
    @(posedge clk); #1;
    check(dec ? "ack_pulse" : "no_ack_undecoded", wbs_ack, dec);
    rd = wbs_dat_o;
    if (dec && !w) check("read_data", wbs_dat_o, exp);
    wbs_stb = 0; wbs_cyc = 0; wbs_we = 0;
    @(posedge clk); #1;
    check("ack_single", wbs_ack, 0);
  endtask

  task automatic la_release();
    la_own = 0;
    m_la_off = cyc_n + 1;
    if (m_pend) begin
      m_pend = 0;
      m_start = cyc_n + 2;
    end
  endtask

  logic [31:0] rdv;
  int t, r0, y;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_csb", csb, 1);
    check("reset_sclk", sclk, 0);
    check("reset_mosi", mosi, 0);
    check("reset_ack", wbs_ack, 0);
    check("reset_dat_o", wbs_dat_o, 0);
    rst = 0;
    chk_en = 1;
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("status_after_reset", rdv, 32'h0);

    // 8-bit frame of 0xA5
    wb(1, BASE, 32'hA5, 4'hF, rdv);
    r0 = rises; t = cyc_n;
    wb(1, BASE + 8, 32'h108, 4'h3, rdv);
    goto(t + 37);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("a5_status_done", rdv, 32'h100);
    check("a5_rises", rises - r0, 8);
    check("a5_bits", bits[7:0], 8'b1010_0101);

    // 40-bit frame spanning both data words
    wb(1, BASE + 4, 32'hFF, 4'hF, rdv);
    wb(1, BASE, 32'h0, 4'hF, rdv);
    r0 = rises; t = cyc_n;
    wb(1, BASE + 8, 32'h128, 4'h3, rdv);
    goto(t + 164);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("len40_status_last_busy", rdv, 32'h101);
    goto(t + 170);
    check("len40_rises", rises - r0, 40);
    check("len40_bits", bits[39:0], 40'hFF_0000_0000);

    // LEN above 64 clamps to a full 64-bit frame
    wb(1, BASE + 4, 32'h8000_0001, 4'hF, rdv);
    wb(1, BASE, 32'h0000_0003, 4'hF, rdv);
    r0 = rises; t = cyc_n;
    wb(1, BASE + 8, 32'h164, 4'h3, rdv);
    goto(t + 264);
    check("clamp_rises", rises - r0, 64);
    check("clamp_bits", bits, 64'h8000_0001_0000_0003);
    wb(0, BASE + 8, 0, 4'hF, rdv);
    check("ctrl_len_readback", rdv, 32'h64);

    // Writes while busy are dropped and flag OVERRUN
    wb(1, BASE, 32'hA5, 4'hF, rdv);
    t = cyc_n;
    wb(1, BASE + 8, 32'h108, 4'h3, rdv);
    wb(1, BASE, 32'h1234, 4'hF, rdv);
    wb(0, BASE, 0, 4'hF, rdv);
    check("overrun_data0_kept", rdv, 32'hA5);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("overrun_set", rdv, 32'h0305);
    wb(1, BASE + 12, 32'h4, 4'h1, rdv);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("overrun_cleared", rdv, 32'h0301);
    goto(t + 40);

    // LA takes the port; START pends until it is released
    la_own = 1; m_la_on = cyc_n + 1; m_la_off = INF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      {la_csb, la_sclk, la_mosi} = 3'(i);
    end
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("la_owner_status", rdv, 32'h0402);
    wb(1, BASE + 8, 32'h108, 4'h3, rdv);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("la_pending_busy", rdv, 32'h0403);
    {la_csb, la_sclk, la_mosi} = 3'b011;
    @(posedge clk); #1;
    y = cyc_n; r0 = rises;
    la_release();
    @(posedge clk); #1;
    check("owner_back_idle_csb", csb, 1);
    @(posedge clk); #1;
    check("pending_frame_setup_csb", csb, 0);
    goto(y + 42);
    check("pending_frame_rises", rises - r0, 8);

    // LA request in the same cycle as START: frame first, then LA
    la_own = 1;
    wb(1, BASE + 8, 32'h108, 4'h3, rdv);
    m_la_on = m_start + m_total + 1; m_la_off = INF;
    goto(m_start + m_total + 3);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("simul_la_after_frame", rdv, 32'h0602);
    la_release();
    repeat (3) begin @(posedge clk); #1; end

    // Non-decoded addresses get no ack
    wb(0, 32'h3000_0010, 0, 4'hF, rdv);
    wb(1, 32'h3100_0000, 32'h55, 4'hF, rdv);

    // Reset during bit 3 aborts the frame
    t = cyc_n;
    wb(1, BASE + 8, 32'h108, 4'h3, rdv);
    goto(m_start + 14);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_d0 = 0; m_d1 = 0; m_len_reg = 0; m_ovr = 0; m_lerr = 0;
    m_active = 0; m_pend = 0; m_done = 0; m_la_on = INF; m_la_off = INF;
    check("abort_csb", csb, 1);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("abort_status", rdv, 32'h0);

    // START with LEN 0 only raises LENERR; byte-lane writes
    r0 = rises;
    wb(1, BASE + 8, 32'h100, 4'h3, rdv);
    repeat (20) begin @(posedge clk); #1; end
    check("lenerr_no_rises", rises - r0, 0);
    wb(0, BASE + 12, 0, 4'hF, rdv);
    check("lenerr_status", rdv, 32'h8);
    wb(1, BASE + 4, 32'hAABB_CCDD, 4'b0101, rdv);
    wb(0, BASE + 4, 0, 4'hF, rdv);
    check("byte_lanes", rdv, 32'h00BB_00DD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
